// File: rtl/inst_uncached_bridge_pkg.sv
// Shared CPU types used by the uncached instruction bridge: FSM state encoding
// and the architectural reset fetch address.
package cpu_pkg;
  typedef enum logic [2:0] {IBR_IDLE, IBR_REQ, IBR_WAIT, IBR_DONE, IBR_DROP} ibr_state_e;
  localparam logic [31:0] TEXT_ADDR = 32'hbfc00000;
endpackage

// File: rtl/inst_uncached_bridge_if.sv
// SRAM-like instruction bus between the uncached bridge (master) and the
// AXI/SRAM arbiter (slave).
interface inst_uncached_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/inst_uncached_bridge.sv
// Turns each uncached fetch into a single SRAM-like bus read; one transaction in
// flight, and data belonging to a flushed fetch is swallowed, never returned.
module inst_uncached_bridge
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(TEXT_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     fetchPc,
  input  logic                  fetchReq,
  input  logic                  fetchStall,
  input  logic                  expFlush,
  output logic                  instSramValid,
  output logic [DATA_W-1:0]     instSramData,
  inst_uncached_bridge_if.master bus
);

  ibr_state_e        state, stateNxt;
  logic              reqQ, reqNxt;
  logic [ADDR_W-1:0] addrQ, addrNxt;
  logic              validQ, validNxt;
  logic [DATA_W-1:0] dataQ, dataNxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IBR_IDLE;
      reqQ   <= 1'b0;
      addrQ  <= RESET_PC;
      validQ <= 1'b0;
      dataQ  <= '0;
    end else begin
      state  <= stateNxt;
      reqQ   <= reqNxt;
      addrQ  <= addrNxt;
      validQ <= validNxt;
      dataQ  <= dataNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    reqNxt   = reqQ;
    addrNxt  = addrQ;
    validNxt = validQ;
    dataNxt  = dataQ;
    unique case (state)
      IBR_IDLE: begin
        if (fetchReq && !expFlush) begin
          addrNxt  = fetchPc;
          reqNxt   = 1'b1;
          stateNxt = IBR_REQ;
        end
      end
      IBR_REQ: begin
        if (expFlush) begin
          reqNxt = 1'b0;
          // An accepted read still owes us data unless it already came back this cycle.
          stateNxt = (bus.inst_addr_ok && !bus.inst_data_ok) ? IBR_DROP : IBR_IDLE;
        end else if (bus.inst_addr_ok) begin
          reqNxt = 1'b0;
          if (bus.inst_data_ok) begin
            dataNxt  = bus.inst_rdata;
            validNxt = 1'b1;
            stateNxt = IBR_DONE;
          end else begin
            stateNxt = IBR_WAIT;
          end
        end
      end
      IBR_WAIT: begin
        if (expFlush) begin
          stateNxt = bus.inst_data_ok ? IBR_IDLE : IBR_DROP;
        end else if (bus.inst_data_ok) begin
          dataNxt  = bus.inst_rdata;
          validNxt = 1'b1;
          stateNxt = IBR_DONE;
        end
      end
      IBR_DONE: begin
        if (expFlush || !fetchStall) begin
          validNxt = 1'b0;
          stateNxt = IBR_IDLE;
        end
      end
      IBR_DROP: begin
        if (bus.inst_data_ok) stateNxt = IBR_IDLE;
      end
      default: stateNxt = IBR_IDLE;
    endcase
  end

  assign bus.inst_req  = reqQ;
  assign bus.inst_addr = addrQ;
  assign instSramValid = validQ;
  assign instSramData  = dataQ;

  // Read data with nothing in flight means the arbiter lost track of us.
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(bus.inst_data_ok && (state == IBR_IDLE || state == IBR_DONE)))
        else $error("inst_uncached_bridge: data_ok with no read in flight");
  end

endmodule

// File: tb/tb_inst_uncached_bridge.sv
// Directed scenarios plus a randomized fetch-stage/arbiter environment checked
// against a transaction-level memory model.
module tb_inst_uncached_bridge;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetchPc;
  logic        fetchReq, fetchStall, expFlush;
  logic        instSramValid;
  logic [31:0] instSramData;
  int          checks = 0;
  int          failures = 0;

  inst_uncached_bridge_if bus();

  inst_uncached_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .fetchPc      (fetchPc),
    .fetchReq     (fetchReq),
    .fetchStall   (fetchStall),
    .expFlush     (expFlush),
    .instSramValid(instSramValid),
    .instSramData (instSramData),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h9e3779b9;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic busIdle();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
  endtask

  // random-phase environment state
  logic [31:0] pc, outAddr, prevAddr, prevPc;
  logic        pending, poisoned, outstanding, reqSeen, prevReq, prevIssue, stallNow;
  int          dataDly, reqWait, d, words, waitCnt, maxWait;

  initial begin
    reset = 1'b1; fetchPc = '0; fetchReq = 1'b0; fetchStall = 1'b0; expFlush = 1'b0;
    busIdle(); bus.inst_rdata = '0;

    // reset
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_req", bus.inst_req, 1'b0);
      chk("rst_valid", instSramValid, 1'b0);
      chk("rst_addr", bus.inst_addr, 32'hbfc00000);
      chk("rst_data", instSramData, 32'h0);
    end
    reset = 1'b0;

    // single fetch with split addr/data handshake
    fetchPc = 32'hbfc00000; fetchReq = 1'b1; fetchStall = 1'b1;
    cyc(); chk("t2_req", bus.inst_req, 1'b1); chk("t2_addr", bus.inst_addr, 32'hbfc00000);
    cyc(); chk("t2_req_hold", bus.inst_req, 1'b1);
    cyc(); chk("t2_req_hold2", bus.inst_req, 1'b1); bus.inst_addr_ok = 1'b1;
    cyc(); bus.inst_addr_ok = 1'b0; chk("t2_req_drop", bus.inst_req, 1'b0);
    chk("t2_wait_valid", instSramValid, 1'b0);
    cyc(); chk("t2_wait_valid2", instSramValid, 1'b0);
    cyc(); chk("t2_wait_valid3", instSramValid, 1'b0);
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3c1d8001;
    cyc(); busIdle(); chk("t2_valid", instSramValid, 1'b1); chk("t2_data", instSramData, 32'h3c1d8001);
    fetchStall = 1'b0; fetchReq = 1'b0;
    cyc(); chk("t2_consumed", instSramValid, 1'b0);

    // addr_ok and data_ok together, then a long stall
    fetchStall = 1'b1; fetchPc = 32'hbfc00004; fetchReq = 1'b1;
    cyc(); chk("t3_req", bus.inst_req, 1'b1);
    bus.inst_addr_ok = 1'b1; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h24000001;
    cyc(); busIdle(); bus.inst_rdata = 32'h11111111;
    chk("t3_req_drop", bus.inst_req, 1'b0);
    chk("t3_valid", instSramValid, 1'b1); chk("t3_data", instSramData, 32'h24000001);
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("t3_stall_valid", instSramValid, 1'b1); chk("t3_stall_data", instSramData, 32'h24000001);
    end
    fetchStall = 1'b0; fetchReq = 1'b0;
    cyc(); chk("t3_consumed", instSramValid, 1'b0); chk("t3_data_kept", instSramData, 32'h24000001);
    fetchStall = 1'b1;

    // flush while waiting for data; late data must be dropped
    fetchPc = 32'hbfc00100; fetchReq = 1'b1;
    cyc(); chk("t4_req", bus.inst_req, 1'b1); bus.inst_addr_ok = 1'b1;
    cyc(); busIdle(); chk("t4_wait_req", bus.inst_req, 1'b0); chk("t4_wait_valid", instSramValid, 1'b0);
    expFlush = 1'b1; fetchReq = 1'b0;
    cyc(); expFlush = 1'b0; chk("t4_drop_valid", instSramValid, 1'b0);
    fetchPc = 32'hbfc00380; fetchReq = 1'b1;
    cyc(); chk("t4_drop_noreq", bus.inst_req, 1'b0); chk("t4_drop_valid2", instSramValid, 1'b0);
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdeadbeef;
    cyc(); busIdle(); chk("t4_idle_noreq", bus.inst_req, 1'b0); chk("t4_no_valid", instSramValid, 1'b0);
    chk("t4_no_stale", instSramData, 32'h24000001);
    cyc(); chk("t4_new_req", bus.inst_req, 1'b1); chk("t4_new_addr", bus.inst_addr, 32'hbfc00380);
    bus.inst_addr_ok = 1'b1; bus.inst_data_ok = 1'b1; bus.inst_rdata = memWord(32'hbfc00380);
    cyc(); busIdle(); chk("t4_valid", instSramValid, 1'b1); chk("t4_data", instSramData, memWord(32'hbfc00380));
    fetchStall = 1'b0; fetchReq = 1'b0;
    cyc(); chk("t4_consumed", instSramValid, 1'b0); fetchStall = 1'b1;

    // flush in REQ without addr_ok: request withdrawn
    fetchPc = 32'hbfc00200; fetchReq = 1'b1;
    cyc(); chk("t5_req", bus.inst_req, 1'b1); expFlush = 1'b1; fetchReq = 1'b0;
    cyc(); expFlush = 1'b0; chk("t5_withdrawn", bus.inst_req, 1'b0);
    cyc(); chk("t5_idle_req", bus.inst_req, 1'b0); chk("t5_idle_valid", instSramValid, 1'b0);

    // flush coincident with addr_ok: drop until data_ok
    fetchPc = 32'hbfc00204; fetchReq = 1'b1;
    cyc(); chk("t5b_req", bus.inst_req, 1'b1);
    expFlush = 1'b1; bus.inst_addr_ok = 1'b1; fetchReq = 1'b0;
    cyc(); expFlush = 1'b0; busIdle(); chk("t5b_drop_req", bus.inst_req, 1'b0);
    fetchPc = 32'hbfc00208; fetchReq = 1'b1;
    cyc(); chk("t5b_drop_ign", bus.inst_req, 1'b0);
    cyc(); chk("t5b_drop_ign2", bus.inst_req, 1'b0);
    bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hcafef00d;
    cyc(); busIdle(); chk("t5b_idle_req", bus.inst_req, 1'b0); chk("t5b_no_valid", instSramValid, 1'b0);
    cyc(); chk("t5b_new_req", bus.inst_req, 1'b1); chk("t5b_new_addr", bus.inst_addr, 32'hbfc00208);
    bus.inst_addr_ok = 1'b1; bus.inst_data_ok = 1'b1; bus.inst_rdata = memWord(32'hbfc00208);
    cyc(); busIdle(); chk("t5b_valid", instSramValid, 1'b1); chk("t5b_data", instSramData, memWord(32'hbfc00208));
    fetchStall = 1'b0; fetchReq = 1'b0;
    cyc(); chk("t5b_consumed", instSramValid, 1'b0);

    // randomized fetch stage + arbiter against the memory model
    pc = 32'hbfc00000; pending = 1'b0; poisoned = 1'b0; outstanding = 1'b0; reqSeen = 1'b0;
    prevReq = bus.inst_req; prevAddr = bus.inst_addr; prevPc = fetchPc; prevIssue = 1'b0;
    dataDly = 0; reqWait = 0; words = 0; waitCnt = 0; maxWait = 0; outAddr = '0;
    for (int cycN = 0; cycN < 10000; cycN++) begin
      cyc();
      if (bus.inst_req && !prevReq) begin
        chk("r_req_pc", bus.inst_addr, prevPc);
        chk("r_req_cause", prevIssue, 1'b1);
        poisoned = 1'b0;
      end
      if (bus.inst_req && prevReq) chk("r_addr_stable", bus.inst_addr, prevAddr);
      if (bus.inst_req && outstanding) chk("r_one_outstanding", 1'b1, 1'b0);
      if (instSramValid) begin
        chk("r_not_flushed", poisoned, 1'b0);
        chk("r_data", instSramData, memWord(pc));
        chk("r_addr", bus.inst_addr, pc);
      end
      if (pending && !instSramValid) waitCnt++; else waitCnt = 0;
      if (waitCnt > maxWait) maxWait = waitCnt;

      // arbiter: random accept and return latency, noise on rdata when idle
      busIdle(); bus.inst_rdata = $urandom;
      if (outstanding) begin
        if (dataDly == 0) begin
          bus.inst_data_ok = 1'b1; bus.inst_rdata = memWord(outAddr); outstanding = 1'b0;
        end else dataDly--;
      end else if (bus.inst_req) begin
        if (!reqSeen) begin reqSeen = 1'b1; reqWait = $urandom_range(0, 7); end
        if (reqWait == 0) begin
          bus.inst_addr_ok = 1'b1; outAddr = bus.inst_addr; reqSeen = 1'b0;
          d = $urandom_range(0, 7);
          if (d == 0) begin bus.inst_data_ok = 1'b1; bus.inst_rdata = memWord(outAddr); end
          else begin outstanding = 1'b1; dataDly = d - 1; end
        end else reqWait--;
      end else reqSeen = 1'b0;

      // fetch stage
      expFlush = 1'b0;
      stallNow = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) begin
        expFlush = 1'b1; fetchReq = 1'b0; pending = 1'b0; poisoned = 1'b1; waitCnt = 0;
        pc = 32'hbfc00000 | (32'($urandom_range(0, 16'hffff)) << 2);
      end else if (pending && instSramValid && !stallNow) begin
        words++; pc = pc + 32'd4;
        pending = ($urandom_range(0, 3) != 0); fetchReq = pending;
      end else if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1; fetchReq = 1'b1;
      end
      fetchStall = stallNow;
      fetchPc = pc;
      prevReq = bus.inst_req; prevAddr = bus.inst_addr; prevPc = fetchPc;
      prevIssue = fetchReq && !expFlush;
    end
    chk("r_progress", 32'(words > 200), 32'd1);
    chk("r_latency_bound", 32'(maxWait <= 40), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
